char_scroller: RTL and testbench



---
 rtl/char_scroller.sv | 198 +++++++++++++++++++
 tb/tb_char_scroller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/char_scroller.sv
// Scrolling multi-digit 7-segment message display fed from a synchronous (1-clock) message memory.
// Latency: an advance moves Pos on its own edge; HEX updates NUM_DIGITS+2 edges after the fetch starts.
// Backpressure: advances arriving mid-fetch still move Pos; one refetch is queued (pending is one deep).
//
// Ports:
//   Clock, Reset      - clock and synchronous active-high reset
//   Enable            - auto-scroll on prescaled tick (prescaler held at 0 when low)
//   Step              - key level; every rising edge requests one advance
//   Dir               - 0: Pos+1 (scroll left), 1: Pos-1 (scroll right)
//   mem_addr/mem_rdata- message memory read port, data valid one clock after the address
//   HEX               - active-low {g,f,e,d,c,b,a} per digit, top digit shows char at Pos
//   Pos               - current window start index
//   Frame             - one-cycle pulse during the commit of a new frame
//   Busy              - high while characters are being fetched
module char_scroller #(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_LEN    = 32,
    parameter int ADDR_W     = 5,
    parameter int TICK_DIV   = 25000000
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Enable,
    input  logic                    Step,
    input  logic                    Dir,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [7:0]              mem_rdata,
    output logic [7*NUM_DIGITS-1:0] HEX,
    output logic [ADDR_W-1:0]       Pos,
    output logic                    Frame,
    output logic                    Busy
);

    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MSG_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_COMMIT
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;       // fetch cycle index 0..NUM_DIGITS
    logic [ADDR_W-1:0]   fa_q, fa_d;         // running fetch address
    logic                pend_q, pend_d;     // one refetch queued
    logic                kick_q, kick_d;     // forces the first fetch after reset
    logic [PW-1:0]       presc_q;
    logic                step_q;
    logic [ADDR_W-1:0]   pos_q;
    logic [6:0]          stage [NUM_DIGITS];
    logic [7*NUM_DIGITS-1:0] hex_q;

    logic                tick;
    logic                step_rise;
    logic                advance;
    logic [ADDR_W-1:0]   pos_inc, pos_dec, pos_nxt, fa_inc;

    function automatic logic [6:0] seg7(input logic [7:0] c);
        case (c)
            8'h41:   seg7 = 7'b0001000; // A
            8'h62:   seg7 = 7'b0000011; // b
            8'h43:   seg7 = 7'b1000110; // C
            8'h64:   seg7 = 7'b0100001; // d
            8'h45:   seg7 = 7'b0000110; // E
            8'h46:   seg7 = 7'b0001110; // F
            8'h67:   seg7 = 7'b0010000; // g
            8'h68:   seg7 = 7'b0001011; // h
            8'h30:   seg7 = 7'b1000000;
            8'h31:   seg7 = 7'b1111001;
            8'h32:   seg7 = 7'b0100100;
            8'h33:   seg7 = 7'b0110000;
            8'h34:   seg7 = 7'b0011001;
            8'h35:   seg7 = 7'b0010010;
            8'h36:   seg7 = 7'b0000010;
            8'h37:   seg7 = 7'b1111000;
            8'h38:   seg7 = 7'b0000000;
            8'h39:   seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // A tick and a step rise on the same edge merge into a single advance.
    assign tick      = Enable && (presc_q == PW'(TICK_DIV - 1));
    assign step_rise = Step && !step_q;
    assign advance   = tick || step_rise;

    assign pos_inc = (pos_q == LAST) ? '0 : pos_q + ADDR_W'(1);
    assign pos_dec = (pos_q == '0) ? LAST : pos_q - ADDR_W'(1);
    assign pos_nxt = advance ? (Dir ? pos_dec : pos_inc) : pos_q;
    assign fa_inc  = (fa_q == LAST) ? '0 : fa_q + ADDR_W'(1);

    assign HEX = hex_q;
    assign Pos = pos_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fa_q    <= '0;
            pend_q  <= 1'b0;
            kick_q  <= 1'b1;
            presc_q <= '0;
            step_q  <= Step;   // primed so a key held through reset is not an edge
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fa_q    <= fa_d;
            pend_q  <= pend_d;
            kick_q  <= kick_d;
            step_q  <= Step;
            pos_q   <= pos_nxt;
            if (!Enable || tick) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

    // Fetch walks NUM_DIGITS addresses; data lands one cycle later, so the
    // state spans NUM_DIGITS+1 cycles. A fetch entered from IDLE or COMMIT
    // latches pos_nxt so an advance on the entry edge is already included.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fa_d     = fa_q;
        pend_d   = pend_q;
        kick_d   = kick_q;
        mem_addr = '0;
        Busy     = 1'b0;
        Frame    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (kick_q || advance) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                    fa_d    = pos_nxt;
                    kick_d  = 1'b0;
                end
            end
            S_FETCH: begin
                Busy = 1'b1;
                if (cnt_q < CW'(NUM_DIGITS)) begin
                    mem_addr = fa_q;
                end
                if (advance) begin
                    pend_d = 1'b1;
                end
                if (cnt_q == CW'(NUM_DIGITS)) begin
                    state_d = S_COMMIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    fa_d  = fa_inc;
                end
            end
            S_COMMIT: begin
                Frame = 1'b1;
                if (pend_q || advance) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                    fa_d    = pos_nxt;
                    pend_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Staging holds decoded segments; the display register only changes as a
    // whole on leaving COMMIT so no partial frame is ever visible.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hex_q <= '1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                stage[i] <= 7'b1111111;
            end
        end else begin
            if (state_q == S_FETCH) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (cnt_q == CW'(i + 1)) begin
                        stage[i] <= seg7(mem_rdata);
                    end
                end
            end
            if (state_q == S_COMMIT) begin
                for (int d = 0; d < NUM_DIGITS; d++) begin
                    hex_q[7*d +: 7] <= stage[NUM_DIGITS-1-d];
                end
            end
        end
    end

endmodule

// File: tb/tb_char_scroller.sv
// Bench for char_scroller: 4 digits, 8-character message, tick every 4 clocks.
// Every cycle is compared with an event-level reference model; directed sequences add fixed expectations.
// Memory model returns data one clock after the address.
module tb_char_scroller;

    localparam int N  = 4;
    localparam int L  = 8;
    localparam int TD = 4;

    localparam logic [6:0] SA = 7'b0001000, SB = 7'b0000011, SC = 7'b1000110, SD = 7'b0100001;
    localparam logic [6:0] SE = 7'b0000110, SF = 7'b0001110, SG = 7'b0010000, SH = 7'b0001011;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100, D3 = 7'b0110000;
    localparam logic [6:0] D4 = 7'b0011001, D5 = 7'b0010010, D6 = 7'b0000010, D7 = 7'b1111000;
    localparam logic [6:0] D8 = 7'b0000000, D9 = 7'b0010000;

    logic        clk = 1'b0;
    logic        rst, en, step, dir;
    logic [2:0]  mem_addr;
    logic [7:0]  mem_rdata;
    logic [27:0] hex;
    logic [2:0]  pos;
    logic        frame, busy;
    logic [7:0]  mem [0:L-1];

    char_scroller #(.NUM_DIGITS(N), .MSG_LEN(L), .ADDR_W(3), .TICK_DIV(TD)) dut (
        .Clock(clk), .Reset(rst), .Enable(en), .Step(step), .Dir(dir),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .HEX(hex), .Pos(pos), .Frame(frame), .Busy(busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= mem[mem_addr];

    int n_checks = 0;
    int n_err    = 0;
    int e        = 0;
    int frames_seen = 0;

    // reference model state
    int          m_pos, m_base, m_s, m_run;
    bit          m_act, m_pend, m_kick, m_prev;
    logic [27:0] m_hex;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (edge %0d)", name, act, exp, e);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [7:0] c);
        case (c)
            "A": return SA;  "b": return SB;  "C": return SC;  "d": return SD;
            "E": return SE;  "F": return SF;  "g": return SG;  "h": return SH;
            "0": return D0;  "1": return D1;  "2": return D2;  "3": return D3;
            "4": return D4;  "5": return D5;  "6": return D6;  "7": return D7;
            "8": return D8;  "9": return D9;
            default: return BL;
        endcase
    endfunction

    // Digit N-1 shows the character at the window start.
    function automatic logic [27:0] ref_frame(input int b);
        logic [27:0] r;
        for (int d = 0; d < N; d++) r[7*d +: 7] = ref_seg(mem[(b + N - 1 - d) % L]);
        return r;
    endfunction

    // One clock edge of the reference: a fetch occupies edges s..s+N+2 and
    // lands its frame on edge s+N+2; advances meanwhile queue one refetch.
    task automatic model_edge();
        bit tick, rise, adv;
        e++;
        if (rst) begin
            m_pos = 0; m_hex = '1; m_act = 0; m_pend = 0; m_kick = 1; m_run = 0; m_prev = step;
            return;
        end
        m_run = en ? m_run + 1 : 0;
        tick  = en && (m_run % TD == 0);
        rise  = step && !m_prev;
        m_prev = step;
        adv   = tick || rise;
        if (adv) m_pos = dir ? (m_pos + L - 1) % L : (m_pos + 1) % L;
        if (m_act && e == m_s + N + 2) begin
            m_hex = ref_frame(m_base);
            m_act = 0;
        end
        if (m_act) begin
            if (adv) m_pend = 1;
        end else if (m_kick || m_pend || adv) begin
            m_act = 1; m_base = m_pos; m_s = e; m_kick = 0; m_pend = 0;
        end
    endtask

    task automatic cyc();
        int k;
        @(posedge clk);
        model_edge();
        #1;
        k = e - m_s;
        if (frame) frames_seen++;
        chk("pos", pos, m_pos);
        chk("hex", hex, m_hex);
        chk("busy", busy, m_act && k <= N);
        chk("frame", frame, m_act && k == N + 1);
        chk("mem_addr", mem_addr, (m_act && k < N) ? (m_base + k) % L : 0);
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic load(input logic [63:0] txt);
        for (int i = 0; i < L; i++) mem[i] = txt[63-8*i -: 8];
    endtask

    typedef struct {
        logic [31:0] txt;
        logic [27:0] exp_hex;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int f0;
        logic [63:0] w;
        vecs[0] = '{"AbCd", {SA, SB, SC, SD}};
        vecs[1] = '{"12 Z", {D1, D2, BL, BL}};
        vecs[2] = '{"EFgh", {SE, SF, SG, SH}};
        vecs[3] = '{"3456", {D3, D4, D5, D6}};
        vecs[4] = '{"7890", {D7, D8, D9, D0}};
        vecs[5] = '{"a-B ", {BL, BL, BL, BL}};

        rst = 1; en = 0; step = 0; dir = 0;
        load("AbCdEFgh");

        // reset state and the automatic first frame
        cyc(); cyc();
        chk("rst_hex", hex, 28'hFFFFFFF);
        chk("rst_pos", pos, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame", frame, 0);
        chk("rst_addr", mem_addr, 0);
        rst = 0;
        f0 = frames_seen;
        run(12);
        chk("boot_frames", frames_seen - f0, 1);
        chk("boot_hex", hex, {SA, SB, SC, SD});
        chk("boot_pos", pos, 0);

        // auto scroll: 40 enabled clocks give 10 ticks
        en = 1;
        run(40);
        en = 0;
        run(15);
        chk("auto_pos", pos, 2);
        chk("auto_hex", hex, {SC, SD, SE, SF});

        // single steps left up to the wrap-around fetch and past the end
        for (int i = 3; i <= 8; i++) begin
            step = 1; cyc(); step = 0; run(10);
            chk("step_pos", pos, i % L);
            if (i == 6) chk("wrap_hex", hex, {SG, SH, SA, SB});
        end

        // step right from 0 wraps to 7; holding the key gives one advance
        dir = 1;
        f0 = frames_seen;
        step = 1;
        run(13);
        chk("right_pos", pos, 7);
        chk("right_frames", frames_seen - f0, 1);
        chk("right_hex", hex, {SH, SA, SB, SC});
        step = 0; dir = 0; cyc();

        // tick and step rise on the same edge count once
        f0 = frames_seen;
        en = 1;
        run(3);
        step = 1; cyc();
        en = 0; step = 0;
        run(15);
        chk("merge_pos", pos, 0);
        chk("merge_frames", frames_seen - f0, 1);

        // two rises during the boot fetch: one queued refetch
        rst = 1; cyc(); cyc(); rst = 0;
        f0 = frames_seen;
        cyc();
        step = 1; cyc(); step = 0; cyc(); step = 1; cyc(); step = 0;
        run(20);
        chk("pend_pos", pos, 2);
        chk("pend_frames", frames_seen - f0, 2);
        chk("pend_hex", hex, {SC, SD, SE, SF});

        // reset during fetch cycle 2
        step = 1; cyc(); cyc(); cyc();
        rst = 1; cyc();
        chk("midrst_hex", hex, 28'hFFFFFFF);
        chk("midrst_pos", pos, 0);
        chk("midrst_busy", busy, 0);
        rst = 0; step = 0;
        run(12);
        chk("midrst_refetch", hex, {SA, SB, SC, SD});

        // decode table
        for (int v = 0; v < 6; v++) begin
            w = {vecs[v].txt, 32'h20202020};
            load(w);
            rst = 1; cyc(); cyc(); rst = 0;
            f0 = frames_seen;
            run(10);
            chk("dec_hex", hex, vecs[v].exp_hex);
            chk("dec_frames", frames_seen - f0, 1);
        end

        // randomized traffic against the model
        load("AbCdEFgh");
        rst = 1; cyc(); rst = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) en = ~en;
            if ($urandom_range(0, 3) == 0) step = ~step;
            dir = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 249) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
